alu_issue_arbiter: RTL

- Shares one combinational alu instance between two requesters (e.g. integer pipe and address/branch helper).
- Round-robin arbitration over valid/ready request ports; drives the ALU's opcode/data_a/data_b from a registered issue stage.
- Captures data_z into a registered response stage returned with requester ID; full throughput of one op per cycle.

---
 rtl/alu_arb_if.sv | 47 ++++
 rtl/alu_issue_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_arb_if.sv
// Request, ALU and response signal bundle for alu_issue_arbiter.
// slave is the arbiter's view; master is the requester/ALU/consumer environment view.
`ifndef WIDTH
`define WIDTH 32
`endif

interface alu_arb_if #(
  parameter int WIDTH = `WIDTH,
  parameter int OPW   = 5
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_opcode;
  logic [WIDTH-1:0] req0_data_a;
  logic [WIDTH-1:0] req0_data_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_opcode;
  logic [WIDTH-1:0] req1_data_a;
  logic [WIDTH-1:0] req1_data_b;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_data_a;
  logic [WIDTH-1:0] alu_data_b;
  logic [WIDTH-1:0] alu_data_z;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data_z;
  logic             rsp_id;

  modport slave (
    input  req0_valid, req0_opcode, req0_data_a, req0_data_b,
    input  req1_valid, req1_opcode, req1_data_a, req1_data_b,
    input  alu_data_z, rsp_ready,
    output req0_ready, req1_ready,
    output alu_opcode, alu_data_a, alu_data_b,
    output rsp_valid, rsp_data_z, rsp_id
  );

  modport master (
    output req0_valid, req0_opcode, req0_data_a, req0_data_b,
    output req1_valid, req1_opcode, req1_data_a, req1_data_b,
    output alu_data_z, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_data_a, alu_data_b,
    input  rsp_valid, rsp_data_z, rsp_id
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two requesters onto one shared combinational ALU, with
// registered issue (s1) and response (s2) stages. Optional ALU_ARB_MPY_MULTICYCLE_EN.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef MPY
`define MPY 5'h02
`endif

module alu_issue_arbiter #(
  parameter int WIDTH = `WIDTH,
  parameter int OPW   = 5
) (
  input logic     clk,
  input logic     rst_n,
  alu_arb_if.slave bus
);
  logic [OPW-1:0]   opcode_p1;
  logic [WIDTH-1:0] data_a_p1;
  logic [WIDTH-1:0] data_b_p1;
  logic             id_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] data_z_p2;
  logic             id_p2;
  logic             vld_p2;
  logic             last_grant;

  logic             grant0, grant1;
  logic             accept0, accept1, accept;
  logic             s1_done, s1_adv, s1_open, s2_open;
  logic [OPW-1:0]   acc_opcode;
  logic [WIDTH-1:0] acc_data_a;
  logic [WIDTH-1:0] acc_data_b;

  // p0: arbitration and handshake
  always_comb begin
    s2_open = !vld_p2 || bus.rsp_ready;
    s1_adv  = vld_p1 && s2_open && s1_done;
    s1_open = !vld_p1 || s1_adv;
    grant0  = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1  = bus.req1_valid && !grant0;
    accept0 = grant0 && s1_open;
    accept1 = grant1 && s1_open;
    accept  = accept0 || accept1;
    acc_opcode = bus.req0_opcode;
    acc_data_a = bus.req0_data_a;
    acc_data_b = bus.req0_data_b;
    if (accept1) begin
      acc_opcode = bus.req1_opcode;
      acc_data_a = bus.req1_data_a;
      acc_data_b = bus.req1_data_b;
    end
  end

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;

`ifdef ALU_ARB_MPY_MULTICYCLE_EN
  // Multiplies hold s1 one extra cycle so the multiplier is a 2-cycle path.
  logic mpy_cnt_p1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mpy_cnt_p1 <= 1'b0;
    else if (accept) mpy_cnt_p1 <= (acc_opcode == OPW'(`MPY));
    else             mpy_cnt_p1 <= 1'b0;
  end
  assign s1_done = !mpy_cnt_p1;
`else
  assign s1_done = 1'b1;
`endif

  // p1: issue register driving the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_p1  <= '0;
      data_a_p1  <= '0;
      data_b_p1  <= '0;
      id_p1      <= 1'b0;
      vld_p1     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      opcode_p1  <= acc_opcode;
      data_a_p1  <= acc_data_a;
      data_b_p1  <= acc_data_b;
      id_p1      <= accept1;
      vld_p1     <= 1'b1;
      last_grant <= accept1;
    end else if (s1_adv) begin
      vld_p1     <= 1'b0;
    end
  end

  assign bus.alu_opcode = opcode_p1;
  assign bus.alu_data_a = data_a_p1;
  assign bus.alu_data_b = data_b_p1;

  // p2: response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_z_p2 <= '0;
      id_p2     <= 1'b0;
      vld_p2    <= 1'b0;
    end else if (s1_adv) begin
      data_z_p2 <= bus.alu_data_z;
      id_p2     <= id_p1;
      vld_p2    <= 1'b1;
    end else if (bus.rsp_ready) begin
      vld_p2    <= 1'b0;
    end
  end

  assign bus.rsp_valid  = vld_p2;
  assign bus.rsp_data_z = data_z_p2;
  assign bus.rsp_id     = id_p2;
endmodule
